// File: rtl/lemming_arena.sv
// Environment model for a two-state walking lemming: tracks position between walls and
// issues bump pulses. Optional in-track obstacle enabled by defining LEMMING_ARENA_OBSTACLE_EN.
module lemming_arena #(
    parameter int POS_W     = 5,
    parameter int ARENA_MAX = 20,
    parameter int START_POS = 0,
    parameter int CNT_W     = 8,
    parameter int TURN_TO   = 4
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             step_en,
    input  logic             walk_left,
    input  logic             walk_right,
`ifdef LEMMING_ARENA_OBSTACLE_EN
    input  logic             obstacle_vld,
    input  logic [POS_W-1:0] obstacle_pos,
`endif
    output logic [POS_W-1:0] pos,
    output logic             bump_left,
    output logic             bump_right,
    output logic [CNT_W-1:0] bump_count,
    output logic             err
);

    localparam int TMR_W = (TURN_TO < 2) ? 1 : $clog2(TURN_TO + 1);
    localparam logic [POS_W-1:0] POS_MAX   = POS_W'(ARENA_MAX);
    localparam logic [POS_W-1:0] POS_START = POS_W'(START_POS);
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TURN_TO - 1);

    typedef enum logic [1:0] {ROAM, WAIT_L, WAIT_R} state_t;

    state_t           state, state_nxt;
    logic [TMR_W-1:0] timer, timer_nxt;
    logic [POS_W-1:0] pos_nxt;
    logic             bump_left_nxt, bump_right_nxt, err_nxt, turn_timeout;
    logic [CNT_W-1:0] bump_count_nxt;
    logic             legal, go_left, go_right, obs_left, obs_right, at_left, at_right;

`ifdef LEMMING_ARENA_OBSTACLE_EN
    // An obstacle sitting on the lemming never matches pos+-1, so it cannot trap it.
    assign obs_left  = obstacle_vld && ({1'b0, pos} == ({1'b0, obstacle_pos} + (POS_W+1)'(1)));
    assign obs_right = obstacle_vld && (obstacle_pos != '0) && (pos == obstacle_pos - POS_W'(1));
`else
    assign obs_left  = 1'b0;
    assign obs_right = 1'b0;
`endif

    assign legal    = walk_left ^ walk_right;
    assign go_left  = legal && walk_left  && step_en && (state == ROAM);
    assign go_right = legal && walk_right && step_en && (state == ROAM);
    assign at_left  = (pos == '0) || obs_left;
    assign at_right = (pos == POS_MAX) || obs_right;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state      <= ROAM;
            timer      <= '0;
            pos        <= POS_START;
            bump_left  <= 1'b0;
            bump_right <= 1'b0;
            bump_count <= '0;
            err        <= 1'b0;
        end else begin
            state      <= state_nxt;
            timer      <= timer_nxt;
            pos        <= pos_nxt;
            bump_left  <= bump_left_nxt;
            bump_right <= bump_right_nxt;
            bump_count <= bump_count_nxt;
            err        <= err_nxt;
        end
    end

    // NOTE: every comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt    = state;
        timer_nxt    = timer;
        turn_timeout = 1'b0;
        unique case (state)
            ROAM: begin
                timer_nxt = '0;
                if (go_left && at_left)        state_nxt = WAIT_L;
                else if (go_right && at_right) state_nxt = WAIT_R;
            end
            WAIT_L, WAIT_R: begin
                if ((state == WAIT_L) ? (!walk_left && walk_right) : (walk_left && !walk_right)) begin
                    state_nxt = ROAM;
                    timer_nxt = '0;
                end else if (timer == TMR_LAST) begin
                    state_nxt    = ROAM;
                    timer_nxt    = '0;
                    turn_timeout = 1'b1;
                end else begin
                    timer_nxt = timer + TMR_W'(1);
                end
            end
            default: begin
                state_nxt = ROAM;
                timer_nxt = '0;
            end
        endcase
    end

    always_comb begin
        pos_nxt        = pos;
        bump_left_nxt  = go_left  && at_left;
        bump_right_nxt = go_right && at_right;
        bump_count_nxt = bump_count;
        err_nxt        = err || !legal || turn_timeout;
        if (go_left && !at_left)   pos_nxt = pos - POS_W'(1);
        if (go_right && !at_right) pos_nxt = pos + POS_W'(1);
        if ((bump_left_nxt || bump_right_nxt) && (bump_count != '1))
            bump_count_nxt = bump_count + CNT_W'(1);
    end

endmodule

// File: doc/lemming_arena.md
Name: lemming_arena

Overview:
- Environment model that drives a two-state walking-lemming FSM.
- Consumes walk_left/walk_right and tracks the lemming's position on a 1-D track bounded by walls at 0 and ARENA_MAX.
- Generates the bump_left/bump_right pulses the walker reacts to.
- Used in closed-loop testbenches and demo tops; wired directly to the walker.

Parameters:
POS_W, 5, width of position register
ARENA_MAX, 20, rightmost legal position (left wall at 0); must be < 2**POS_W
START_POS, 0, position loaded on reset
CNT_W, 8, width of bump counter
TURN_TO, 4, cycles allowed for walker to turn after a bump before error

Ports:
clk  input  1  clock, rising edge
areset  input  1  asynchronous active-high reset
step_en  input  1  advance lemming one position this cycle
walk_left  input  1  walker heading left
walk_right  input  1  walker heading right
pos  output  POS_W  current position
bump_left  output  1  one-cycle pulse: hit left wall
bump_right  output  1  one-cycle pulse: hit right wall
bump_count  output  CNT_W  total bumps since reset, saturating
err  output  1  sticky: illegal walk encoding or turn timeout

Behaviour:
- Interface: reset areset, asynchronous, active-high; clock clk.
- Reset values: pos=START_POS, bump_left=0, bump_right=0, bump_count=0, err=0, state=ROAM, turn timer=0.
- All outputs are registered.
- FSM states: ROAM, WAIT_L, WAIT_R.
- ROAM, step_en=1, walk_left=1 and walk_right=0:
  - pos>0: pos<=pos-1.
  - pos==0: no move; bump_left<=1 for exactly one cycle; bump_count++ (saturate at all-ones); go to WAIT_L; timer cleared.
- ROAM, walk_right=1 and walk_left=0: symmetric. Increment up to ARENA_MAX; at ARENA_MAX pulse bump_right, count, go to WAIT_R.
- ROAM, step_en=0: no move, no bump.
- Illegal encoding: walk_left==walk_right in any state sets err<=1 (sticky until reset). No movement that cycle.
- WAIT_L:
  - bump_left deasserts the cycle after entry.
  - Position frozen; step_en ignored.
  - walk_left==0 and walk_right==1: return to ROAM. No move in that cycle.
  - Otherwise increment timer. Timer reaching TURN_TO sets err<=1 and returns to ROAM.
  - No second bump_left is issued while in WAIT_L.
- WAIT_R: symmetric to WAIT_L.
- Walker latency: with the walker attached, bump at edge k causes the walker to turn at edge k+1, so the arena returns to ROAM at edge k+2.
- Reset mid-bump: all pulses clear immediately (asynchronous) and the FSM returns to ROAM at START_POS.
- Saturation: bump_count holds at 2**CNT_W-1.
- pos never leaves [0, ARENA_MAX].
- bump_left and bump_right are never high together.

Optional Feature:
- LEMMING_ARENA_OBSTACLE_EN defined:
  - Adds ports obstacle_vld (input, 1) and obstacle_pos (input, POS_W).
  - While obstacle_vld=1, the obstacle acts as a wall. A left-moving lemming at pos==obstacle_pos+1, or a right-moving lemming at pos==obstacle_pos-1, bumps instead of moving. Counting and the WAIT state apply exactly as for the outer walls.
  - obstacle_pos==pos is ignored (no trapping).
- Undefined: ports absent; only the outer walls exist.

Test Plan:
- Reset: assert areset mid-cycle -> pos=0, bump_count=0, err=0, bumps low immediately, without waiting for a clock edge.
- Left wall, walker attached, step_en=1 continuous from pos=0 -> bump_left high for exactly 1 cycle, bump_count=1, walker turns, pos increments 1,2,3... from the cycle after return to ROAM.
- Right wall, START_POS=18, walk_right=1 -> pos 19, 20, then bump_right one cycle, pos stays 20, bump_count=1.
- Turn timeout: bump_left issued, hold walk_left=1 for TURN_TO=4 cycles -> err=1 on 4th cycle, no second bump_left, state returns to ROAM.
- Illegal encoding: walk_left=walk_right=1 at pos=5 with step_en=1 -> pos stays 5, err=1 and remains 1 until areset.
- Saturation (CNT_W=2): drive 5 wall bumps -> bump_count reads 1, 2, 3, 3, 3.
